// File: rtl/ahb_slave_mem_responder_pkg.sv
// Shared AHB types for the memory responder: transfer/response encodings, size codes, slave FSM states.
// Latency: none (types, constants and a pure byte-enable helper only).
// Backpressure: not applicable.
package AHB_package;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_type;

  typedef enum logic {
    OKAY  = 1'b0,
    ERROR = 1'b1
  } hresp_type;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR1 = 2'd2,
    S_ERR2 = 2'd3
  } slave_state_t;

  // Little-endian lane mask for a legal (aligned) transfer of the given size.
  function automatic logic [3:0] byte_enable(input logic [2:0] size, input logic [1:0] off);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << off;
      HSIZE_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: be = 4'b1111;
      default:    be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ahb_slave_mem_responder_if.sv
// AHB slave-side bus bundle between the interconnect and the memory responder.
// Latency: none (wires only).
// Backpressure: hreadyout from the slave, hready from the interconnect.
interface ahb_slave_mem_responder_if #(
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int AHB_DATA_WIDTH = 32
);
  import AHB_package::*;

  logic                      hsel;
  logic [AHB_ADDR_WIDTH-1:0] haddr;
  htrans_type                htrans;
  logic                      hwrite;
  logic [2:0]                hsize;
  logic [AHB_DATA_WIDTH-1:0] hwdata;
  logic                      hready;
  logic                      hreadyout;
  hresp_type                 hresp;
  logic [AHB_DATA_WIDTH-1:0] hrdata;

  // Bus side: master/decoder/interconnect drive the request and bus-level ready.
  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
    output hreadyout, hresp, hrdata
  );

endinterface

// File: rtl/ahb_slave_mem_responder_mem_array.sv
// Word-addressed 32-bit storage with byte-lane write enables; contents are never reset.
// Latency: read is combinational, write lands at the rising edge.
// Backpressure: none; always accepts writes.
module ahb_slave_mem_array #(
  parameter int MEM_DEPTH = 256,
  parameter int IDX_W     = $clog2(MEM_DEPTH)
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [3:0]       wr_be,
  input  logic [31:0]      wr_data
);

  logic [31:0] mem [MEM_DEPTH];

  assign rd_data = mem[rd_idx];

  // Byte-granular write of the enabled lanes only.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) begin
          mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/ahb_slave_mem_responder.sv
// AHB memory slave: accepts address phases, serves reads/writes after WAIT_STATES, two-cycle ERROR for illegal transfers.
// Latency: OKAY completes WAIT_STATES+1 cycles after acceptance; ERROR takes two cycles.
// Backpressure: hreadyout low during wait states and the first ERROR cycle; no acceptance while hready is low.
module ahb_slave_mem_responder
  import AHB_package::*;
#(
  parameter int                        AHB_ADDR_WIDTH = 32,
  parameter int                        AHB_DATA_WIDTH = 32,
  parameter int                        MEM_DEPTH      = 256,
  parameter logic [AHB_ADDR_WIDTH-1:0] BASE_ADDR      = 32'h0000_0400,
  parameter int unsigned               WAIT_STATES    = 0
) (
  input  logic                      hclk,
  input  logic                      hreset_n,
  ahb_slave_mem_responder_if.slave  bus
);

  localparam int                        IDX_W  = $clog2(MEM_DEPTH);
  localparam logic [AHB_ADDR_WIDTH-1:0] REGION = AHB_ADDR_WIDTH'(4 * MEM_DEPTH);
  localparam logic [3:0]                WS     = 4'(WAIT_STATES);

  slave_state_t              state, state_nxt;
  logic [3:0]                cnt, cnt_nxt;
  logic                      dphase, dphase_nxt;
  logic [IDX_W-1:0]          idx_q;
  logic [1:0]                off_q;
  logic [2:0]                size_q;
  logic                      write_q;

  logic [AHB_ADDR_WIDTH-1:0] rel_addr;
  logic                      accept;
  logic                      addr_err;
  logic                      completing;
  logic [AHB_DATA_WIDTH-1:0] rd_data;

  assign rel_addr = bus.haddr - BASE_ADDR;

  // Only S_IDLE (plain idle or an OKAY completion) may take a new address phase;
  // an address phase overlapping S_ERR2 is dropped on purpose.
  assign accept = bus.hsel && bus.hready && (state == S_IDLE) &&
                  ((bus.htrans == NONSEQ) || (bus.htrans == SEQ));

  assign addr_err = (rel_addr >= REGION) ||
                    (bus.hsize > HSIZE_WORD) ||
                    ((bus.hsize == HSIZE_HALF) && bus.haddr[0]) ||
                    ((bus.hsize == HSIZE_WORD) && (bus.haddr[1:0] != 2'b00));

  // The data phase of a legal transfer finishes in S_IDLE with dphase set.
  assign completing = (state == S_IDLE) && dphase;

  // State, wait counter and captured address-phase fields.
  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      dphase  <= 1'b0;
      idx_q   <= '0;
      off_q   <= 2'b00;
      size_q  <= HSIZE_BYTE;
      write_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      dphase <= dphase_nxt;
      if (accept) begin
        idx_q   <= rel_addr[IDX_W+1:2];
        off_q   <= bus.haddr[1:0];
        size_q  <= bus.hsize;
        write_q <= bus.hwrite;
      end
    end
  end

  // Next-state logic: legal transfers go straight to completion or through S_WAIT, illegal ones to ERROR.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    dphase_nxt = dphase;
    case (state)
      S_IDLE: begin
        dphase_nxt = 1'b0;
        if (accept) begin
          if (addr_err) begin
            state_nxt = S_ERR1;
          end else if (WS != 4'd0) begin
            state_nxt  = S_WAIT;
            cnt_nxt    = WS - 4'd1;
            dphase_nxt = 1'b1;
          end else begin
            dphase_nxt = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_ERR1: begin
        state_nxt  = S_ERR2;
        dphase_nxt = 1'b0;
      end
      S_ERR2: begin
        state_nxt  = S_IDLE;
        dphase_nxt = 1'b0;
      end
      default: begin
        state_nxt  = S_IDLE;
        dphase_nxt = 1'b0;
      end
    endcase
  end

  assign bus.hreadyout = (state != S_WAIT) && (state != S_ERR1);
  assign bus.hresp     = ((state == S_ERR1) || (state == S_ERR2)) ? ERROR : OKAY;
  assign bus.hrdata    = (completing && !write_q) ? rd_data : '0;

  ahb_slave_mem_array #(
    .MEM_DEPTH (MEM_DEPTH),
    .IDX_W     (IDX_W)
  ) u_mem (
    .clk     (hclk),
    .rd_idx  (idx_q),
    .rd_data (rd_data),
    .wr_en   (completing && write_q && hreset_n),
    .wr_idx  (idx_q),
    .wr_be   (byte_enable(size_q, off_q)),
    .wr_data (bus.hwdata)
  );

endmodule

// File: tb/tb_ahb_slave_mem_responder.sv
// Scoreboard bench: three responders (0, 2 and 3 wait states) share one driver; a monitor checks every cycle.
// Latency: expected records are consumed when the monitor sees an address phase accepted.
// Backpressure: the driver holds each address phase until the selected slave's hready is high.
module tb_ahb_slave_mem_responder;
  import AHB_package::*;

  typedef struct {
    logic        err;
    int          waits;
    logic [31:0] rdata;
  } exp_t;

  logic        hclk;
  logic        rst_n;
  logic [1:0]  d_sel;
  logic        d_hsel;
  logic [31:0] d_haddr;
  htrans_type  d_htrans;
  logic        d_hwrite;
  logic [2:0]  d_hsize;
  logic [31:0] d_hwdata;
  logic        stall;

  int checks;
  int errors;
  exp_t q[$];
  int ws_of[3] = '{0, 2, 3};

  ahb_slave_mem_responder_if #(.AHB_ADDR_WIDTH(32), .AHB_DATA_WIDTH(32)) bus0 ();
  ahb_slave_mem_responder_if #(.AHB_ADDR_WIDTH(32), .AHB_DATA_WIDTH(32)) bus1 ();
  ahb_slave_mem_responder_if #(.AHB_ADDR_WIDTH(32), .AHB_DATA_WIDTH(32)) bus2 ();

  assign bus0.hsel   = d_hsel && (d_sel == 2'd0);
  assign bus0.haddr  = d_haddr;
  assign bus0.htrans = d_htrans;
  assign bus0.hwrite = d_hwrite;
  assign bus0.hsize  = d_hsize;
  assign bus0.hwdata = d_hwdata;
  assign bus0.hready = !stall && bus0.hreadyout;

  assign bus1.hsel   = d_hsel && (d_sel == 2'd1);
  assign bus1.haddr  = d_haddr;
  assign bus1.htrans = d_htrans;
  assign bus1.hwrite = d_hwrite;
  assign bus1.hsize  = d_hsize;
  assign bus1.hwdata = d_hwdata;
  assign bus1.hready = !stall && bus1.hreadyout;

  assign bus2.hsel   = d_hsel && (d_sel == 2'd2);
  assign bus2.haddr  = d_haddr;
  assign bus2.htrans = d_htrans;
  assign bus2.hwrite = d_hwrite;
  assign bus2.hsize  = d_hsize;
  assign bus2.hwdata = d_hwdata;
  assign bus2.hready = !stall && bus2.hreadyout;

  ahb_slave_mem_responder #(.WAIT_STATES(0)) u0 (.hclk(hclk), .hreset_n(rst_n), .bus(bus0));
  ahb_slave_mem_responder #(.WAIT_STATES(2)) u1 (.hclk(hclk), .hreset_n(rst_n), .bus(bus1));
  ahb_slave_mem_responder #(.WAIT_STATES(3)) u2 (.hclk(hclk), .hreset_n(rst_n), .bus(bus2));

  logic        obs_rdy;
  logic        obs_hready;
  hresp_type   obs_resp;
  logic [31:0] obs_rdata;

  // View of whichever slave the driver currently targets.
  always_comb begin
    obs_rdy    = bus0.hreadyout;
    obs_hready = bus0.hready;
    obs_resp   = bus0.hresp;
    obs_rdata  = bus0.hrdata;
    case (d_sel)
      2'd1: begin
        obs_rdy = bus1.hreadyout; obs_hready = bus1.hready; obs_resp = bus1.hresp; obs_rdata = bus1.hrdata;
      end
      2'd2: begin
        obs_rdy = bus2.hreadyout; obs_hready = bus2.hready; obs_resp = bus2.hresp; obs_rdata = bus2.hrdata;
      end
      default: ;
    endcase
  end

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge hclk);
      #1;
    end
  endtask

  // Drive one address phase on slave d, wait for acceptance, then present its write data.
  task automatic issue(input logic [1:0] d, input htrans_type tr, input logic wr, input logic [2:0] sz,
                       input logic [31:0] ad, input logic [31:0] wd, input logic err, input logic [31:0] rexp);
    exp_t e;
    logic got;
    e.err   = err;
    e.waits = ws_of[d];
    e.rdata = (err || wr) ? 32'h0 : rexp;
    q.push_back(e);
    d_sel = d; d_hsel = 1'b1; d_htrans = tr; d_hwrite = wr; d_hsize = sz; d_haddr = ad;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge hclk);
      got = obs_hready;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout addr %h: hready stayed 0, expected 1", ad);
    end
    @(posedge hclk);
    #1;
    d_hwdata = wd;
    d_hsel   = 1'b0;
    d_htrans = IDLE;
    if (err) idle(2);
  endtask

  // Monitor: per-cycle comparison of the targeted slave against the expected record in flight.
  initial begin : monitor
    exp_t cur;
    logic busy;
    logic done_err;
    int   cyc;
    busy = 1'b0;
    cyc  = 0;
    forever begin
      @(negedge hclk);
      if (!rst_n) begin
        busy = 1'b0;
      end else begin
        done_err = 1'b0;
        if (busy) begin
          cyc++;
          if (cur.err) begin
            chk("err_hreadyout", obs_rdy, (cyc >= 2));
            chk("err_hresp", obs_resp, ERROR);
            chk("err_hrdata", obs_rdata, 32'h0);
            if (cyc >= 2) begin
              busy = 1'b0;
              done_err = 1'b1;
            end
          end else if (cyc <= cur.waits) begin
            chk("wait_hreadyout", obs_rdy, 1'b0);
            chk("wait_hresp", obs_resp, OKAY);
            chk("wait_hrdata", obs_rdata, 32'h0);
          end else begin
            chk("done_hreadyout", obs_rdy, 1'b1);
            chk("done_hresp", obs_resp, OKAY);
            chk("done_hrdata", obs_rdata, cur.rdata);
            busy = 1'b0;
          end
        end else begin
          chk("idle_hreadyout", obs_rdy, 1'b1);
          chk("idle_hresp", obs_resp, OKAY);
          chk("idle_hrdata", obs_rdata, 32'h0);
        end
        if (!busy && !done_err && d_hsel && obs_hready && (d_htrans == NONSEQ || d_htrans == SEQ)) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_accept addr %h: accepted, expected no transfer", d_haddr);
          end else begin
            cur  = q.pop_front();
            busy = 1'b1;
            cyc  = 0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
    $fatal(1);
  end

  initial begin : stimulus
    checks = 0; errors = 0;
    rst_n = 1'b0; stall = 1'b0; d_sel = 2'd0; d_hsel = 1'b0; d_haddr = 32'h0;
    d_htrans = IDLE; d_hwrite = 1'b0; d_hsize = HSIZE_WORD; d_hwdata = 32'h0;
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // Zero-wait slave: word, half-word and byte writes with read-back.
    issue(0, NONSEQ, 1, HSIZE_WORD, 32'h404, 32'hDEADBEEF, 0, 0);
    issue(0, NONSEQ, 0, HSIZE_WORD, 32'h404, 32'h0, 0, 32'hDEADBEEF);
    issue(0, NONSEQ, 1, HSIZE_HALF, 32'h406, 32'h12345678, 0, 0);
    issue(0, SEQ,    0, HSIZE_WORD, 32'h404, 32'h0, 0, 32'h1234BEEF);
    issue(0, NONSEQ, 1, HSIZE_BYTE, 32'h405, 32'hAABBCCDD, 0, 0);
    issue(0, NONSEQ, 0, HSIZE_WORD, 32'h404, 32'h0, 0, 32'h1234CCEF);

    // Illegal transfers: misaligned, oversize, out of range above and below the region.
    issue(0, NONSEQ, 0, HSIZE_WORD, 32'h402, 32'h0, 1, 0);
    issue(0, NONSEQ, 0, HSIZE_HALF, 32'h405, 32'h0, 1, 0);
    issue(0, NONSEQ, 0, 3'd3,       32'h404, 32'h0, 1, 0);
    issue(0, NONSEQ, 1, HSIZE_WORD, 32'h400, 32'hCAFEF00D, 0, 0);
    issue(0, NONSEQ, 1, HSIZE_WORD, 32'h800, 32'hFFFFFFFF, 1, 0);
    issue(0, NONSEQ, 1, HSIZE_WORD, 32'h3FC, 32'hFFFFFFFF, 1, 0);
    issue(0, NONSEQ, 0, HSIZE_WORD, 32'h400, 32'h0, 0, 32'hCAFEF00D);
    issue(0, NONSEQ, 1, HSIZE_WORD, 32'h7FC, 32'h13579BDF, 0, 0);
    issue(0, NONSEQ, 0, HSIZE_WORD, 32'h7FC, 32'h0, 0, 32'h13579BDF);

    // Back-to-back read-after-write, then IDLE/BUSY with hsel high.
    issue(0, NONSEQ, 1, HSIZE_WORD, 32'h408, 32'h5A5A5A5A, 0, 0);
    issue(0, NONSEQ, 0, HSIZE_WORD, 32'h408, 32'h0, 0, 32'h5A5A5A5A);
    d_hsel = 1'b1; d_htrans = BUSY; d_haddr = 32'h404; d_hwrite = 1'b1;
    idle(1);
    d_htrans = IDLE;
    idle(1);
    d_hsel = 1'b0;

    // Bus stalled by another slave: the address phase must not be taken.
    issue(0, NONSEQ, 1, HSIZE_WORD, 32'h40C, 32'h01020304, 0, 0);
    idle(1);
    stall = 1'b1; d_hsel = 1'b1; d_htrans = NONSEQ; d_hwrite = 1'b1; d_haddr = 32'h40C; d_hwdata = 32'hFFFFFFFF;
    idle(2);
    d_hsel = 1'b0; d_htrans = IDLE; stall = 1'b0;
    idle(1);
    issue(0, NONSEQ, 0, HSIZE_WORD, 32'h40C, 32'h0, 0, 32'h01020304);
    idle(2);

    // Two wait states: byte lane merge, error timing, back-to-back RAW.
    issue(1, NONSEQ, 1, HSIZE_WORD, 32'h404, 32'h11223344, 0, 0);
    issue(1, NONSEQ, 1, HSIZE_BYTE, 32'h406, 32'hA5A5A5A5, 0, 0);
    issue(1, NONSEQ, 0, HSIZE_WORD, 32'h404, 32'h0, 0, 32'h11A53344);
    issue(1, NONSEQ, 0, HSIZE_WORD, 32'h402, 32'h0, 1, 0);
    issue(1, NONSEQ, 1, HSIZE_WORD, 32'h408, 32'h0F0F0F0F, 0, 0);
    issue(1, NONSEQ, 0, HSIZE_WORD, 32'h408, 32'h0, 0, 32'h0F0F0F0F);
    idle(4);

    // Three wait states: reset in the second wait cycle aborts the write.
    issue(2, NONSEQ, 1, HSIZE_WORD, 32'h410, 32'h0BADF00D, 0, 0);
    idle(5);
    issue(2, NONSEQ, 1, HSIZE_WORD, 32'h410, 32'hFFFFFFFF, 0, 0);
    idle(1);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(2);
    issue(2, NONSEQ, 0, HSIZE_WORD, 32'h410, 32'h0, 0, 32'h0BADF00D);
    idle(6);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d records left, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
